// File: rtl/mem_arbiter_ctrl.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared word memory.
// Alternates grants on ties, fixed WAIT-cycle access latency, one-cycle ack per access.
module mem_arbiter_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WAIT   = 2
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_ack,
    input  logic              D_req,
    input  logic              D_we,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_ack,
    output logic              Busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              take_c;
    logic              pick_d_c;
    logic              commit_c;

    logic              last_d;
    logic              lat_d;
    logic              lat_we;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    // Only the word-index bits of each address take part in the access.
    logic unused_addr;
    assign unused_addr = ^{I_addr, D_addr};

    // Next-state: grant in IDLE, count down in WAIT, single ACK cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        take_c     = 1'b0;
        pick_d_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (I_req || D_req) begin
                    take_c     = 1'b1;
                    pick_d_c   = D_req && (!I_req || !last_d);
                    state_next = ST_WAIT;
                    cnt_next   = CNT_W'(WAIT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    commit_c   = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, grant latch and registered outputs.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_d    <= 1'b0;
            lat_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            I_ack     <= 1'b0;
            D_ack     <= 1'b0;
            I_rdata   <= '0;
            D_rdata   <= '0;
            Busy      <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            Busy  <= (state_next != ST_IDLE);
            I_ack <= commit_c && !lat_d;
            D_ack <= commit_c && lat_d;
            if (take_c) begin
                last_d    <= pick_d_c;
                lat_d     <= pick_d_c;
                lat_we    <= pick_d_c && D_we;
                lat_idx   <= pick_d_c ? D_addr[IDX_W+1:2] : I_addr[IDX_W+1:2];
                lat_wdata <= D_wdata;
            end
            if (commit_c && !lat_we) begin
                if (lat_d) begin
                    D_rdata <= mem[lat_idx];
                end else begin
                    I_rdata <= mem[lat_idx];
                end
            end
        end
    end

    // Storage is not reset; a reset before the commit edge leaves state IDLE so no write occurs.
    always_ff @(posedge Clk) begin
        if (commit_c && lat_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed self-checking bench for mem_arbiter_ctrl (WAIT=2 main instance, WAIT=1 pipeline instance).
module tb_mem_arbiter_ctrl;

    logic        clk;
    logic        clrn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        busy;

    logic        i_req1;
    logic [31:0] i_addr1;
    logic [31:0] i_rdata1;
    logic        i_ack1;
    logic [31:0] d_rdata1;
    logic        d_ack1;
    logic        busy1;

    int checks   = 0;
    int failures = 0;

    mem_arbiter_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(2)) dut (
        .Clk(clk), .Clrn(clrn),
        .I_req(i_req), .I_addr(i_addr), .I_rdata(i_rdata), .I_ack(i_ack),
        .D_req(d_req), .D_we(d_we), .D_addr(d_addr), .D_wdata(d_wdata),
        .D_rdata(d_rdata), .D_ack(d_ack), .Busy(busy)
    );

    mem_arbiter_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(1)) dut1 (
        .Clk(clk), .Clrn(clrn),
        .I_req(i_req1), .I_addr(i_addr1), .I_rdata(i_rdata1), .I_ack(i_ack1),
        .D_req(1'b0), .D_we(1'b0), .D_addr(32'h0), .D_wdata(32'h0),
        .D_rdata(d_rdata1), .D_ack(d_ack1), .Busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one data-port access, returns data and number of ticks until D_ack (>3 on timeout).
    task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int cycles);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!d_ack && cycles < 20);
        rd = d_rdata;
        d_req = 1'b0;
        tick();
    endtask

    task automatic do_i(input logic [31:0] addr, output logic [31:0] rd, output int cycles);
        i_req = 1'b1; i_addr = addr;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!i_ack && cycles < 20);
        rd = i_rdata;
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0;
        tick(); tick();
        checks++;
        if ({i_ack, d_ack, busy, i_rdata, d_rdata} !== 67'h0) begin
            failures++;
            $display("FAIL reset_outputs got ack_i=%b ack_d=%b busy=%b i_rdata=%h d_rdata=%h want all 0",
                     i_ack, d_ack, busy, i_rdata, d_rdata);
        end
        clrn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int cyc;
        do_d(1'b1, 32'h10, 32'hDEADBEEF, rd, cyc);
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL write_latency got %0d ticks want 3", cyc);
        end
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL write_keeps_d_rdata got %h want 00000000", rd);
        end
        do_i(32'h10, rd, cyc);
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL i_read_latency got %0d ticks want 3", cyc);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL i_read_data got %h want deadbeef", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int cyc;
        do_d(1'b1, 32'h0, 32'h5, rd, cyc);
        do_d(1'b0, 32'h400, 32'h0, rd, cyc);
        checks++;
        if (rd !== 32'h5) begin
            failures++;
            $display("FAIL wrap_read_400 got %h want 00000005", rd);
        end
        do_d(1'b0, 32'h10, 32'h0, rd, cyc);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL d_read_10 got %h want deadbeef", rd);
        end
        do_d(1'b0, 32'h3, 32'h0, rd, cyc);
        checks++;
        if (rd !== 32'h5) begin
            failures++;
            $display("FAIL lowbits_read_3 got %h want 00000005", rd);
        end
        do_i(32'h3, rd, cyc);
        checks++;
        if (rd !== 32'h5) begin
            failures++;
            $display("FAIL i_lowbits_read_3 got %h want 00000005", rd);
        end
    endtask

    task automatic test_both();
        int ack_tick[$];
        logic ack_d[$];
        logic [31:0] last_i;
        logic [31:0] last_dr;
        int overlap;
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        overlap = 0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (i_ack && d_ack) overlap++;
            if (i_ack || d_ack) begin
                ack_tick.push_back(t);
                ack_d.push_back(d_ack);
            end
        end
        last_i = i_rdata;
        last_dr = d_rdata;
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL tie_overlap got %0d overlapping cycles want 0", overlap);
        end
        checks++;
        if (ack_tick.size() !== 3) begin
            failures++;
            $display("FAIL tie_ack_count got %0d want 3", ack_tick.size());
        end else begin
            checks++;
            if (ack_d[0] !== 1'b1 || ack_d[1] !== 1'b0 || ack_d[2] !== 1'b1) begin
                failures++;
                $display("FAIL tie_order got d=%b,%b,%b want 1,0,1", ack_d[0], ack_d[1], ack_d[2]);
            end
            checks++;
            if (ack_tick[0] !== 3 || ack_tick[1] !== 7 || ack_tick[2] !== 11) begin
                failures++;
                $display("FAIL tie_timing got %0d,%0d,%0d want 3,7,11", ack_tick[0], ack_tick[1], ack_tick[2]);
            end
        end
        checks++;
        if (last_i !== 32'h5 || last_dr !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL tie_data got i=%h d=%h want 00000005 deadbeef", last_i, last_dr);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        int cyc;
        int acks;
        do_d(1'b1, 32'h20, 32'h0, rd, cyc);
        do_d(1'b0, 32'h10, 32'h0, rd, cyc);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_after_grant got %b want 1", busy);
        end
        #1 clrn = 1'b0;
        #1;
        checks++;
        if ({i_ack, d_ack, busy, i_rdata, d_rdata} !== 67'h0) begin
            failures++;
            $display("FAIL abort_async_clear got ack_i=%b ack_d=%b busy=%b i_rdata=%h d_rdata=%h want all 0",
                     i_ack, d_ack, busy, i_rdata, d_rdata);
        end
        d_req = 1'b0;
        #1 clrn = 1'b1;
        acks = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (d_ack || i_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL abort_no_ack got %0d acks want 0", acks);
        end
        do_d(1'b0, 32'h20, 32'h0, rd, cyc);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL abort_no_write got %h want 00000000", rd);
        end
    endtask

    task automatic test_input_change();
        logic [31:0] rd;
        int cyc;
        do_d(1'b1, 32'h34, 32'h22222222, rd, cyc);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hA5A5A5A5;
        tick();
        d_addr = 32'h34; d_wdata = 32'h11111111; d_req = 1'b0;
        cyc = 1;
        while (!d_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("FAIL change_dropped_req_latency got %0d ticks want 3", cyc);
        end
        do_d(1'b0, 32'h30, 32'h0, rd, cyc);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL change_orig_written got %h want a5a5a5a5", rd);
        end
        do_d(1'b0, 32'h34, 32'h0, rd, cyc);
        checks++;
        if (rd !== 32'h22222222) begin
            failures++;
            $display("FAIL change_new_untouched got %h want 22222222", rd);
        end
    endtask

    task automatic test_wait1();
        int bad_ack;
        int bad_busy;
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        i_req1 = 1'b1; i_addr1 = 32'h8;
        bad_ack = 0; bad_busy = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (i_ack1 !== ((t % 3) == 2)) bad_ack++;
            if (busy1 !== ((t % 3) != 0)) bad_busy++;
        end
        i_req1 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bad_ack !== 0) begin
            failures++;
            $display("FAIL wait1_ack_every_3rd got %0d wrong cycles want 0", bad_ack);
        end
        checks++;
        if (bad_busy !== 0) begin
            failures++;
            $display("FAIL wait1_busy_pattern got %0d wrong cycles want 0", bad_busy);
        end
        checks++;
        if (busy1 !== 1'b0 || d_ack1 !== 1'b0 || d_rdata1 !== 32'h0) begin
            failures++;
            $display("FAIL wait1_idle_tail got busy=%b d_ack=%b d_rdata=%h want 0 0 00000000",
                     busy1, d_ack1, d_rdata1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_both();
        test_reset_abort();
        test_input_change();
        test_wait1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached want completion");
        $fatal(1, "timeout");
    end

endmodule
